melody_sequencer: RTL and testbench



---
 rtl/melody_pkg.sv | 34 +++
 rtl/melody_sequencer_if.sv | 30 +++
 rtl/note_timer.sv | 35 +++
 rtl/melody_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, ROM word
// layout and the duration-code to slot-multiplier mapping.
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_GAP,
    ST_PLAY,
    ST_PAUSE
  } state_e;

  localparam int ROM_W  = 8;
  localparam int NOTE_W = 6;

  localparam logic [1:0] DUR_16  = 2'd0;
  localparam logic [1:0] DUR_8   = 2'd1;
  localparam logic [1:0] DUR_4   = 2'd2;
  localparam logic [1:0] DUR_END = 2'd3;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

  // A 16th slot is the unit; longer notes scale both gap and sound phases.
  function automatic logic [2:0] dur_mult(input logic [1:0] dur);
    logic [2:0] m;
    case (dur)
      DUR_8:   m = 3'd2;
      DUR_4:   m = 3'd4;
      default: m = 3'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Bundle between the button/switch logic, the note ROM and the tone generator
// on one side (master) and the melody sequencer on the other (slave).
interface melody_sequencer_if #(
  parameter int SONG_BITS = 2,
  parameter int LEN_BITS  = 6
);
  import melody_pkg::*;

  logic                          start;
  logic                          pause;
  logic                          stop;
  logic [SONG_BITS-1:0]          song_sel;
  logic [SONG_BITS+LEN_BITS-1:0] rom_addr;
  logic [ROM_W-1:0]              rom_data;
  logic [NOTE_W-1:0]             note_code;
  logic                          note_on;
  logic                          busy;
  logic                          done;

  modport master (
    output start, pause, stop, song_sel, rom_data,
    input  rom_addr, note_code, note_on, busy, done
  );

  modport slave (
    input  start, pause, stop, song_sel, rom_data,
    output rom_addr, note_code, note_on, busy, done
  );

endinterface

// File: rtl/note_timer.sv
// Loadable 32-bit down-counter shared by the GAP and PLAY phases; it stops at
// zero and flags expiry while it reads zero.
module note_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] load_value,
  output logic [31:0] value,
  output logic        expired
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (!hold && value_q != 32'd0) begin
      value_d = value_q - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 32'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == 32'd0);

endmodule

// File: rtl/melody_sequencer.sv
// Walks the note ROM and turns each word into a silent gap plus a sounding phase.
// Define MELODY_LOOP_EN to replay the song endlessly instead of returning to idle.
module melody_sequencer #(
  parameter int unsigned PLAY_16   = 10_000_000,
  parameter int unsigned GAP_16    = 2_500_000,
  parameter int          SONG_BITS = 2,
  parameter int          LEN_BITS  = 6
) (
  input  logic                clk,
  input  logic                rst,
  melody_sequencer_if.slave   bus
);
  import melody_pkg::*;

  localparam logic [31:0] PLAY_W = 32'(PLAY_16);
  localparam logic [31:0] GAP_W  = 32'(GAP_16);

  state_e                        state_q, state_d;
  state_e                        ret_q, ret_d;
  logic                          fetch2_q, fetch2_d;
  logic [SONG_BITS-1:0]          song_q, song_d;
  logic [LEN_BITS-1:0]           idx_q, idx_d;
  logic [2:0]                    mult_q, mult_d;
  logic [NOTE_W-1:0]             note_q, note_d;
  logic [SONG_BITS+LEN_BITS-1:0] addr_q, addr_d;
  logic                          note_on_q, note_on_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          tmr_load, tmr_hold, tmr_expired;
  logic [31:0]                   tmr_load_val, tmr_value;
  logic [LEN_BITS-1:0]           idx_inc;
  logic [2:0]                    rom_mult;
  logic                          end_song;

  note_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .hold       (tmr_hold),
    .load_value (tmr_load_val),
    .value      (tmr_value),
    .expired    (tmr_expired)
  );

  assign idx_inc  = idx_q + LEN_BITS'(1);
  assign rom_mult = dur_mult(bus.rom_data[7:6]);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    fetch2_d     = fetch2_q;
    song_d       = song_q;
    idx_d        = idx_q;
    mult_d       = mult_q;
    note_d       = note_q;
    addr_d       = addr_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_hold     = 1'b1;
    tmr_load_val = 32'd0;
    end_song     = 1'b0;

    if (bus.stop) begin
      state_d  = ST_IDLE;
      fetch2_d = 1'b0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            song_d   = bus.song_sel;
            idx_d    = '0;
            addr_d   = {bus.song_sel, {LEN_BITS{1'b0}}};
            fetch2_d = 1'b0;
            state_d  = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!fetch2_q) begin
            fetch2_d = 1'b1;
          end else begin
            fetch2_d = 1'b0;
            if (bus.rom_data[7:6] == DUR_END) begin
              end_song = 1'b1;
            end else begin
              note_d       = bus.rom_data[NOTE_W-1:0];
              mult_d       = rom_mult;
              tmr_load     = 1'b1;
              tmr_load_val = GAP_W * 32'(rom_mult) - 32'd1;
              state_d      = ST_GAP;
            end
          end
        end
        // The cycle that samples pause still consumes one count, so the
        // phase keeps its full length across a pause.
        ST_GAP: begin
          tmr_hold = 1'b0;
          if (bus.pause && tmr_value != 32'd0) begin
            ret_d   = ST_GAP;
            state_d = ST_PAUSE;
          end else if (tmr_expired) begin
            tmr_load     = 1'b1;
            tmr_load_val = PLAY_W * 32'(mult_q) - 32'd1;
            state_d      = ST_PLAY;
          end
        end
        ST_PLAY: begin
          tmr_hold = 1'b0;
          if (bus.pause && tmr_value != 32'd0) begin
            ret_d   = ST_PLAY;
            state_d = ST_PAUSE;
          end else if (tmr_expired) begin
            if (idx_q == {LEN_BITS{1'b1}}) begin
              end_song = 1'b1;
            end else begin
              idx_d    = idx_inc;
              addr_d   = {song_q, idx_inc};
              fetch2_d = 1'b0;
              state_d  = ST_FETCH;
            end
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) begin
            state_d = ret_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (end_song) begin
      done_d = 1'b1;
`ifdef MELODY_LOOP_EN
      idx_d    = '0;
      addr_d   = {song_q, {LEN_BITS{1'b0}}};
      fetch2_d = 1'b0;
      state_d  = ST_FETCH;
`else
      state_d  = ST_IDLE;
`endif
    end

    busy_d    = (state_d != ST_IDLE);
    note_on_d = (state_d == ST_PLAY) && (note_d != NOTE_REST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_GAP;
      fetch2_q  <= 1'b0;
      song_q    <= '0;
      idx_q     <= '0;
      mult_q    <= 3'd1;
      note_q    <= NOTE_REST;
      addr_q    <= '0;
      note_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      fetch2_q  <= fetch2_d;
      song_q    <= song_d;
      idx_q     <= idx_d;
      mult_q    <= mult_d;
      note_q    <= note_d;
      addr_q    <= addr_d;
      note_on_q <= note_on_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.note_code = note_q;
  assign bus.note_on   = note_on_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with PLAY_16=4, GAP_16=1, LEN_BITS=3;
// expectations are hand-derived cycle positions counted from the start edge.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  melody_sequencer_if #(.SONG_BITS(2), .LEN_BITS(3)) bus ();

  melody_sequencer #(
    .PLAY_16   (4),
    .GAP_16    (1),
    .SONG_BITS (2),
    .LEN_BITS  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:31];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int checks = 0;
  int passes = 0;

  logic       on_tr   [0:160];
  logic [5:0] code_tr [0:160];
  logic       done_tr [0:160];
  logic       busy_tr [0:160];
  logic [4:0] addr_tr [0:160];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start with the given song and records n cycles (t=1 is just after
  // the edge that accepts start); pause and stop+start are scheduled by cycle.
  task automatic applyStimulus(input logic [1:0] song, input int n, input int pause_on,
                               input int pause_off, input int stop_at);
    bus.song_sel = song;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.song_sel = ~song;
    for (int t = 1; t <= n; t++) begin
      if (t > 1) begin
        @(posedge clk); #1;
      end
      on_tr[t]   = bus.note_on;
      code_tr[t] = bus.note_code;
      done_tr[t] = bus.done;
      busy_tr[t] = bus.busy;
      addr_tr[t] = bus.rom_addr;
      bus.pause  = (t >= pause_on) && (t < pause_off);
      bus.stop   = (t == stop_at);
      bus.start  = (t == stop_at);
    end
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    bus.start = 1'b0;
  endtask

  function automatic int countOn(input int lo, input int hi, input int code);
    int c = 0;
    for (int t = lo; t <= hi; t++) begin
      if (on_tr[t] && (code < 0 || int'(code_tr[t]) == code)) c++;
    end
    return c;
  endfunction

  function automatic int countDone(input int lo, input int hi);
    int c = 0;
    for (int t = lo; t <= hi; t++) begin
      if (done_tr[t]) c++;
    end
    return c;
  endfunction

  initial begin
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.stop     = 1'b0;
    bus.song_sel = 2'd0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'h08;
    rom[1]  = 8'h49;
    rom[2]  = 8'hC0;
    rom[8]  = 8'h80;
    rom[9]  = 8'hC0;
    rom[16] = 8'h45;
    rom[17] = 8'hC0;
    for (int i = 0; i < 8; i++) rom[24 + i] = 8'(i + 1);

    #12;
    checkOutput("reset_flags", {29'd0, bus.note_on, bus.busy, bus.done}, 32'd0);
    checkOutput("reset_addr",  bus.rom_addr, 32'd0);
    checkOutput("reset_code",  bus.note_code, 32'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("idle_busy", bus.busy, 32'd0);

    // Song 0: 16th note 8, 8th note 9, end word.
    applyStimulus(2'd0, 26, 0, 0, 0);
    checkOutput("s0_rise",     {30'd0, on_tr[3], on_tr[4]}, 32'd1);
    checkOutput("s0_note8",    countOn(1, 26, 8), 32'd4);
    checkOutput("s0_note9",    countOn(1, 26, 9), 32'd8);
    checkOutput("s0_fall",     on_tr[20], 32'd0);
    checkOutput("s0_done_pos", done_tr[22], 32'd1);
    checkOutput("s0_done_cnt", countDone(1, 26), 32'd1);
    checkOutput("s0_busy",     {30'd0, busy_tr[21], busy_tr[22]}, 32'd2);

    // Song 1: quarter rest, 4 gap + 16 play cycles of silence.
    applyStimulus(2'd1, 28, 0, 0, 0);
    checkOutput("rest_on",    countOn(1, 25, -1), 32'd0);
    checkOutput("rest_addr",  {27'd0, addr_tr[22]}, 32'd8);
    checkOutput("rest_next",  {27'd0, addr_tr[23]}, 32'd9);
    checkOutput("rest_busy",  busy_tr[24], 32'd1);
    checkOutput("rest_done",  done_tr[25], 32'd1);

    // Song 2: 8th note 5 paused for 10 cycles with 2 play cycles left.
    applyStimulus(2'd2, 28, 10, 20, 0);
    checkOutput("pause_pre",   countOn(5, 10, 5), 32'd6);
    checkOutput("pause_low",   countOn(11, 20, -1), 32'd0);
    checkOutput("pause_post",  countOn(21, 22, 5), 32'd2);
    checkOutput("pause_end",   on_tr[23], 32'd0);
    checkOutput("pause_done",  done_tr[25], 32'd1);

    // Song 0 again, stop together with start during the first play phase.
    applyStimulus(2'd0, 12, 0, 0, 5);
    checkOutput("stop_before", on_tr[5], 32'd1);
    checkOutput("stop_on",     on_tr[6], 32'd0);
    checkOutput("stop_busy",   {30'd0, busy_tr[6], busy_tr[12]}, 32'd0);
    checkOutput("stop_done",   countDone(1, 12), 32'd0);

    // Song 3: eight 16th notes and no end word, wraps after index 7.
    applyStimulus(2'd3, 120, 0, 0, 0);
    checkOutput("wrap_last",   {27'd0, addr_tr[50]}, 32'd31);
    checkOutput("wrap_done",   done_tr[57], 32'd1);
`ifdef MELODY_LOOP_EN
    checkOutput("wrap_count",  countDone(1, 120), 32'd2);
    checkOutput("wrap_busy",   busy_tr[57], 32'd1);
    checkOutput("wrap_addr",   {27'd0, addr_tr[57]}, 32'd24);
`else
    checkOutput("wrap_count",  countDone(1, 120), 32'd1);
    checkOutput("wrap_busy",   busy_tr[57], 32'd0);
    checkOutput("wrap_addr",   {27'd0, addr_tr[57]}, 32'd31);
`endif
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    checkOutput("wrap_stop", bus.busy, 32'd0);

    // Reset in the middle of a gap, then in the middle of a play phase.
    applyStimulus(2'd2, 3, 0, 0, 0);
    checkOutput("gap_state", {26'd0, busy_tr[3], addr_tr[3]}, 32'd48);
    rst = 1'b1;
    #1;
    checkOutput("rst_gap_flags", {29'd0, bus.note_on, bus.busy, bus.done}, 32'd0);
    checkOutput("rst_gap_addr",  bus.rom_addr, 32'd0);
    checkOutput("rst_gap_code",  bus.note_code, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'd0, 5, 0, 0, 0);
    checkOutput("play_state", on_tr[5], 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_play_on", bus.note_on, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'd2, 1, 0, 0, 0);
    checkOutput("restart_addr", {27'd0, addr_tr[1]}, 32'd16);
    checkOutput("restart_busy", busy_tr[1], 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
